// File: rtl/instr_mem_pipe_pkg.sv
// Shared ARM fetch definitions: the canonical NOP, the legal fetch latency
// range and the per-stage pipeline record.
package instr_mem_pipe_pkg;

    localparam logic [31:0] ARM_NOP      = 32'hE1A00000;  // MOV R0,R0
    localparam int          LATENCY_MIN  = 1;
    localparam int          LATENCY_MAX  = 4;
    localparam int          STAGE_ADDR_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [STAGE_ADDR_W-1:0] addr;
        logic                    err;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{valid: 1'b0, addr: '0, err: 1'b0};

endpackage

// File: rtl/imem_stage.sv
// One freezable/flushable fetch pipeline register. An empty stage always
// holds the idle record and the NOP word so downstream outputs stay clean.
module imem_stage
    import instr_mem_pipe_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_WORD = ARM_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              d_valid,
    input  logic              d_err,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_instr,
    output logic              q_valid,
    output logic              q_err,
    output logic [ADDR_W-1:0] q_addr,
    output logic [31:0]       q_instr
);

    stage_t      r;
    logic [31:0] r_instr;

    // clr (flush) wins over a held stage; en low means the stage is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r       <= STAGE_IDLE;
            r_instr <= NOP_WORD;
        end else if (clr || (en && !d_valid)) begin
            r       <= STAGE_IDLE;
            r_instr <= NOP_WORD;
        end else if (en) begin
            r       <= '{valid: 1'b1, addr: STAGE_ADDR_W'(d_addr), err: d_err};
            r_instr <= d_err ? NOP_WORD : d_instr;
        end
    end

    assign q_valid = r.valid;
    assign q_err   = r.err;
    assign q_addr  = ADDR_W'(r.addr);
    assign q_instr = r_instr;

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory with a program-load port and a LATENCY-deep fetch
// pipeline supporting freeze (stall) and flush (taken branch).
module instr_mem_pipe
    import instr_mem_pipe_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = ARM_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              freeze,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              rsp_valid,
    output logic [31:0]       rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("instr_mem_pipe: LATENCY out of range");
    end
    if (ADDR_W > STAGE_ADDR_W || ADDR_W < IDX_W + 2) begin : g_bad_addr_w
        $error("instr_mem_pipe: ADDR_W incompatible with DEPTH or stage record");
    end

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
    endfunction

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;
    logic             req_bad;
    logic             accept;
    logic [31:0]      fetch_word;

    assign req_ready  = !freeze && !load_en;
    assign accept     = req_valid && req_ready;
    assign req_idx    = req_addr[IDX_W+1:2];
    assign load_idx   = load_addr[IDX_W+1:2];
    assign req_bad    = addr_bad(req_addr);
    // Out-of-range fetches never touch the array; the NOP is muxed in instead.
    assign fetch_word = req_bad ? NOP_WORD : mem[req_idx];

    // NOTE: the array has no reset so it maps onto RAM and keeps the program across rst.
    always_ff @(posedge clk) begin
        if (load_en && !addr_bad(load_addr)) begin
            mem[load_idx] <= load_data;
        end
    end

    logic              st_valid [LATENCY];
    logic              st_err   [LATENCY];
    logic [ADDR_W-1:0] st_addr  [LATENCY];
    logic [31:0]       st_instr [LATENCY];

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic              d_valid;
        logic              d_err;
        logic [ADDR_W-1:0] d_addr;
        logic [31:0]       d_instr;
        logic              en;
        logic              clr;

        // The head stage loads during a flush so the branch target survives it.
        if (i == 0) begin : g_head
            assign d_valid = accept;
            assign d_err   = req_bad;
            assign d_addr  = req_addr;
            assign d_instr = fetch_word;
            assign en      = !freeze || flush;
            assign clr     = 1'b0;
        end else begin : g_body
            assign d_valid = st_valid[i-1];
            assign d_err   = st_err[i-1];
            assign d_addr  = st_addr[i-1];
            assign d_instr = st_instr[i-1];
            assign en      = !freeze;
            assign clr     = flush;
        end

        imem_stage #(
            .ADDR_W   (ADDR_W),
            .NOP_WORD (NOP_WORD)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clr     (clr),
            .d_valid (d_valid),
            .d_err   (d_err),
            .d_addr  (d_addr),
            .d_instr (d_instr),
            .q_valid (st_valid[i]),
            .q_err   (st_err[i]),
            .q_addr  (st_addr[i]),
            .q_instr (st_instr[i])
        );
    end

    assign rsp_valid = st_valid[LATENCY-1];
    assign rsp_err   = st_err[LATENCY-1];
    assign rsp_addr  = st_addr[LATENCY-1];
    assign rsp_instr = st_instr[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe: directed scenarios plus random
// traffic against a queue-based model of in-flight fetches.
module tb_instr_mem_pipe;

    localparam int          ADDR_W  = 32;
    localparam int          DEPTH   = 256;
    localparam int          LATENCY = 2;
    localparam logic [31:0] NOP     = 32'hE1A00000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              freeze;
    logic              flush;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              rsp_valid;
    logic [31:0]       rsp_instr;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;

    always #5 clk = ~clk;

    instr_mem_pipe #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .LATENCY  (LATENCY),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .freeze    (freeze),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-flight fetches with the number of active edges seen.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          age;
    } ent_t;

    ent_t        inflight[$];
    logic [31:0] ref_mem [DEPTH];

    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * DEPTH);
    endfunction

    task automatic check_outputs(input string tag);
        logic        v = 1'b0;
        logic [31:0] ins = NOP;
        logic [31:0] a = '0;
        logic        e = 1'b0;
        foreach (inflight[i]) begin
            if (inflight[i].age == LATENCY) begin
                v   = 1'b1;
                ins = inflight[i].instr;
                a   = inflight[i].addr;
                e   = inflight[i].err;
            end
        end
        check({tag, ".valid"}, 64'(rsp_valid), 64'(v));
        check({tag, ".instr"}, 64'(rsp_instr), 64'(ins));
        check({tag, ".addr"},  64'(rsp_addr),  64'(a));
        check({tag, ".err"},   64'(rsp_err),   64'(e));
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] a,
                         input logic frz, input logic fl,
                         input logic ld, input logic [31:0] la, input logic [31:0] ldd);
        logic acc;
        ent_t ne;
        req_valid = v;  req_addr  = a;  freeze    = frz; flush = fl;
        load_en   = ld; load_addr = la; load_data = ldd;
        #1;
        check({tag, ".ready"}, 64'(req_ready), 64'(!frz && !ld));
        acc = v && !frz && !ld;
        ne.addr  = a;
        ne.err   = bad_addr(a);
        ne.instr = ne.err ? NOP : ref_mem[(a / 4) % DEPTH];
        ne.age   = 1;
        @(posedge clk);
        if (fl) begin
            inflight.delete();
        end else if (!frz) begin
            foreach (inflight[i]) inflight[i].age++;
            while (inflight.size() > 0 && inflight[0].age > LATENCY) void'(inflight.pop_front());
        end
        if (acc) inflight.push_back(ne);
        if (ld && !bad_addr(la)) ref_mem[la / 4] = ldd;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        cycle(tag, 1'b1, a, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic load(input logic [31:0] la, input logic [31:0] d);
        cycle("load", 1'b0, '0, 1'b0, 1'b0, 1'b1, la, d);
    endtask

    logic [31:0] rnd_addr;
    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'hE3A00014; prog[1] = 32'hE3A01A01;
        prog[2] = 32'hE3A02103; prog[3] = 32'hE0923002;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; freeze = 1'b0; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        @(negedge clk); @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Fill the whole array so every later fetch has a known word.
        for (int i = 0; i < DEPTH; i++) load(32'(4 * i), $urandom);
        for (int i = 0; i < 4; i++) load(32'(4 * i), prog[i]);
        idle("idle0", 2);

        // Program words back-to-back
        for (int i = 0; i < 4; i++) fetch("prog", 32'(4 * i));
        idle("prog_drain", LATENCY + 1);

        // Misaligned and out-of-range fetches
        fetch("err_mis", 32'd6);
        fetch("err_oor", 32'(4 * DEPTH));
        idle("err_drain", LATENCY);
        fetch("err_mis2", 32'd6);
        cycle("err_wait", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        if (LATENCY > 2) idle("err_wait2", LATENCY - 2);
        check("err_nop_literal", 64'(rsp_instr), 64'(32'hE1A00000));
        check("err_flag_literal", 64'(rsp_err), 64'd1);
        idle("err_drain2", LATENCY + 1);

        // Stream with a 3-cycle freeze in the middle
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int k = 0; k < 3; k++)
                    cycle("freeze", 1'b1, 32'(16 + 4 * i), 1'b1, 1'b0, 1'b0, '0, '0);
            end
            fetch("stream", 32'(16 + 4 * i));
        end
        idle("stream_drain", LATENCY + 1);

        // Two fetches in flight, flush with branch target 60
        fetch("pre_flush", 32'd100);
        fetch("pre_flush", 32'd104);
        cycle("flush", 1'b1, 32'd60, 1'b0, 1'b1, 1'b0, '0, '0);
        idle("post_flush", LATENCY + 1);
        // Flush overriding freeze
        fetch("pre_flush2", 32'd108);
        cycle("flush_frz", 1'b1, 32'd112, 1'b1, 1'b1, 1'b0, '0, '0);
        idle("post_flush2", LATENCY + 1);

        // Reset with fetches in flight
        fetch("pre_rst", 32'd0);
        fetch("pre_rst", 32'd4);
        fetch("pre_rst", 32'd8);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async.valid", 64'(rsp_valid), 64'd0);
        check("rst_async.err",   64'(rsp_err),   64'd0);
        check("rst_async.instr", 64'(rsp_instr), 64'(NOP));
        check("rst_async.addr",  64'(rsp_addr),  64'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        inflight.delete();
        idle("post_rst", LATENCY + 1);
        for (int i = 0; i < 4; i++) fetch("refetch", 32'(4 * i));
        idle("refetch_drain", LATENCY + 1);

        // Load colliding with a request, then retry
        cycle("ld_collide", 1'b1, 32'd20, 1'b0, 1'b0, 1'b1, 32'd20, 32'hCAFEF00D);
        fetch("ld_retry", 32'd20);
        idle("ld_drain", LATENCY + 1);
        // Out-of-range / misaligned loads leave memory alone
        load(32'(4 * DEPTH), 32'h12345678);
        load(32'd22, 32'h87654321);
        fetch("ld_ignored", 32'd20);
        idle("ld_drain2", LATENCY + 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       rnd_addr = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'd1;
                1:       rnd_addr = 32'(4 * DEPTH + 4 * $urandom_range(0, 63));
                default: rnd_addr = 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            cycle("rand",
                  1'($urandom_range(0, 3) != 0), rnd_addr,
                  1'($urandom_range(0, 99) < 15),
                  1'($urandom_range(0, 99) < 8),
                  1'($urandom_range(0, 99) < 10),
                  32'(4 * $urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle("final_drain", LATENCY + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_pipe.md
INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 The module SHALL have parameter DEPTH, default 256, meaning number of 32-bit instruction words (power of two).
REQ-003 The module SHALL have parameter LATENCY, default 2, meaning request-to-response cycles, legal range 1..4.
REQ-004 The module SHALL have parameter NOP_WORD, default 32'hE1A00000 (MOV R0,R0), meaning the word returned on error or flush.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port req_valid, input, 1 bit: fetch request present.
REQ-008 The module SHALL have port req_addr, input, ADDR_W bits: byte address of the fetch.
REQ-009 The module SHALL have port req_ready, output, 1 bit: request accepted this cycle if req_valid is also 1.
REQ-010 The module SHALL have port freeze, input, 1 bit: pipeline hold (hazard stall).
REQ-011 The module SHALL have port flush, input, 1 bit: kill all in-flight fetches (taken branch).
REQ-012 The module SHALL have port load_en, input, 1 bit: program-load write strobe.
REQ-013 The module SHALL have port load_addr, input, ADDR_W bits: byte address of the program-load write.
REQ-014 The module SHALL have port load_data, input, 32 bits: program-load word.
REQ-015 The module SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-016 The module SHALL have port rsp_instr, output, 32 bits: fetched instruction.
REQ-017 The module SHALL have port rsp_addr, output, ADDR_W bits: address of the returned instruction.
REQ-018 The module SHALL have port rsp_err, output, 1 bit: misaligned (addr[1:0]!=0) or out-of-range (word index >= DEPTH) fetch.

Function
REQ-019 Storage SHALL be DEPTH x 32 words indexed by addr[log2(DEPTH)+1:2]; it SHALL be written only through the load port.
REQ-020 req_ready SHALL equal !freeze && !load_en; a request SHALL be accepted iff req_valid && req_ready.
REQ-021 An accepted request SHALL produce rsp_valid=1 exactly LATENCY active (non-frozen) cycles later, in request order, one response per request; throughput SHALL be one per cycle.
REQ-022 While freeze=1, every pipeline stage including rsp_* SHALL hold its value and no request SHALL be accepted.
REQ-023 flush=1 SHALL clear the valid bit of every in-flight stage (rsp_valid=0 next cycle), overriding freeze.
REQ-024 A request presented in a flush cycle SHALL be accepted when req_ready=1 (new branch target survives the flush).
REQ-025 Erroneous fetches SHALL return rsp_valid=1, rsp_err=1, rsp_instr=NOP_WORD; memory SHALL NOT be read out of range.
REQ-026 load_en=1 SHALL write load_data to the indexed word at the clock edge; misaligned or out-of-range loads SHALL be ignored.
REQ-027 Whenever rsp_valid=0, rsp_instr SHALL be NOP_WORD, rsp_err=0 and rsp_addr=0.
REQ-028 A load SHALL be visible to any fetch accepted in a later cycle.

Reset
REQ-029 Asserting rst SHALL immediately clear all pipeline valid bits: rsp_valid=0, rsp_err=0, rsp_instr=NOP_WORD, rsp_addr=0.
REQ-030 Reset SHALL NOT clear memory contents; fetches in flight at reset SHALL be discarded with no response.

Structure
REQ-031 NOP_WORD, the LATENCY legal range and the stage record (valid, addr, err) SHALL live in the shared ARM package.
REQ-032 One sub-module, imem_stage, SHALL implement a single freezable/flushable pipeline register, instantiated LATENCY times.

Verification
REQ-033 Load words 0..3 = 0xE3A00014, 0xE3A01A01, 0xE3A02103, 0xE0923002; fetch addrs 0,4,8,12 back-to-back -> same words with rsp_valid, in order, LATENCY cycles each.
REQ-034 Fetch addr 6 and addr 4*DEPTH -> rsp_err=1, rsp_instr=0xE1A00000.
REQ-035 Stream fetches, assert freeze 3 cycles mid-stream -> rsp held, req_ready=0, no response lost or duplicated.
REQ-036 Two fetches in flight, flush with request addr 60 -> in-flight responses dropped, only addr 60 returned.
REQ-037 Assert rst with fetches in flight -> rsp_valid=0 immediately; memory words unchanged on refetch.
REQ-038 load_en with req_valid in the same cycle -> req_ready=0; retried fetch of that address returns the new word.
